// File: rtl/unified_cache_xbar.sv
// Crossbar between requesting ports and unified-cache banks: round-robin request routing to
// per-bank output registers and return routing back to per-port registers.
// Optional build macro: UNIFIED_CACHE_XBAR_CRITICAL_PRIORITY_EN (critical requests win first).

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 40
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 36
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 39
`endif

// Round-robin picker: first candidate at index >= ptr, wrapping.
module unified_cache_xbar_rr_arb #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] win,
  output logic [W-1:0] next_ptr
);

  int          sum;
  int          nxt_i;
  logic [W-1:0] idx_w;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = 0;
    idx_w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx_w = W'(sum);
      if (cand[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  always_comb begin
    nxt_i = int'(win) + 1;
    if (nxt_i >= N) nxt_i = 0;
    next_ptr = W'(nxt_i);
  end

endmodule

module unified_cache_xbar #(
  parameter int NUM_INPUT_PORT  = 2,
  parameter int NUM_BANK        = 4,
  parameter int PACKET_WIDTH    = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int BANK_SEL_POS_LO = 2,
  parameter int PORT_ID_POS_LO  = `UNIFIED_CACHE_PACKET_PORT_NUM_LO,
  parameter int PORT_ID_WIDTH   = $clog2(NUM_INPUT_PORT) + 1,
  parameter int VALID_POS       = `UNIFIED_CACHE_PACKET_VALID_POS
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] request_flatted_in,
  input  logic [NUM_INPUT_PORT-1:0]              request_critical_flatted_in,
  output logic [NUM_INPUT_PORT-1:0]              request_ack_out,
  output logic [NUM_BANK*PACKET_WIDTH-1:0]       bank_request_flatted_out,
  output logic [NUM_BANK-1:0]                    bank_request_valid_out,
  input  logic [NUM_BANK-1:0]                    bank_request_ack_in,
  input  logic [NUM_BANK*PACKET_WIDTH-1:0]       bank_return_flatted_in,
  output logic [NUM_BANK-1:0]                    bank_return_ack_out,
  output logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] return_packet_flatted_out,
  input  logic [NUM_INPUT_PORT-1:0]              return_packet_ack_in
);

  localparam int BANK_W     = $clog2(NUM_BANK);
  localparam int PORT_PTR_W = (NUM_INPUT_PORT > 1) ? $clog2(NUM_INPUT_PORT) : 1;

  // Handshake: a source offers a packet by holding its VALID_POS bit high; the xbar pulses the
  // source's ack for one cycle when it captures the packet, after which the source may change it.
  // An output register is loadable when empty or when its consumer acks in the same cycle.

  logic [PACKET_WIDTH-1:0] req_pkt [NUM_INPUT_PORT];
  logic [PACKET_WIDTH-1:0] ret_pkt [NUM_BANK];

  logic [NUM_BANK-1:0][NUM_INPUT_PORT-1:0] req_gnt;
  logic [NUM_INPUT_PORT-1:0][NUM_BANK-1:0] ret_gnt;

  for (genvar p = 0; p < NUM_INPUT_PORT; p++) begin : g_req_unpack
    assign req_pkt[p] = request_flatted_in[p*PACKET_WIDTH +: PACKET_WIDTH];
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_ret_unpack
    assign ret_pkt[b] = bank_return_flatted_in[b*PACKET_WIDTH +: PACKET_WIDTH];
  end

`ifndef UNIFIED_CACHE_XBAR_CRITICAL_PRIORITY_EN
  logic unused_critical;
  assign unused_critical = ^request_critical_flatted_in;
`endif

  // Request path: one output register per bank.
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [NUM_INPUT_PORT-1:0] pend;
    logic [NUM_INPUT_PORT-1:0] cand;
    logic [PORT_PTR_W-1:0]     rr_q;
    logic [PORT_PTR_W-1:0]     win;
    logic [PORT_PTR_W-1:0]     nxt;
    logic                      found;
    logic                      open;
    logic                      grant;
    logic [PACKET_WIDTH-1:0]   pkt_q;
    logic                      vld_q;

    always_comb begin
      pend = '0;
      for (int p = 0; p < NUM_INPUT_PORT; p++) begin
        pend[p] = req_pkt[p][VALID_POS] &&
                  (req_pkt[p][BANK_SEL_POS_LO +: BANK_W] == BANK_W'(b));
      end
    end

`ifdef UNIFIED_CACHE_XBAR_CRITICAL_PRIORITY_EN
    assign cand = (|(pend & request_critical_flatted_in)) ?
                  (pend & request_critical_flatted_in) : pend;
`else
    assign cand = pend;
`endif

    unified_cache_xbar_rr_arb #(
      .N (NUM_INPUT_PORT),
      .W (PORT_PTR_W)
    ) u_arb (
      .cand     (cand),
      .ptr      (rr_q),
      .found    (found),
      .win      (win),
      .next_ptr (nxt)
    );

    assign open  = !vld_q || bank_request_ack_in[b];
    assign grant = open && found && !reset_in;
    assign req_gnt[b] = grant ? (NUM_INPUT_PORT'(1) << win) : '0;

    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        pkt_q <= '0;
        vld_q <= 1'b0;
        rr_q  <= '0;
      end else if (grant) begin
        pkt_q <= req_pkt[win];
        vld_q <= 1'b1;
        rr_q  <= nxt;
      end else if (vld_q && bank_request_ack_in[b]) begin
        pkt_q <= '0;
        vld_q <= 1'b0;
      end
    end

    assign bank_request_flatted_out[b*PACKET_WIDTH +: PACKET_WIDTH] = pkt_q;
    assign bank_request_valid_out[b] = vld_q;
  end

  // Return path: one output register per port; port-ids outside the port range match no port.
  for (genvar p = 0; p < NUM_INPUT_PORT; p++) begin : g_port
    logic [NUM_BANK-1:0]     cand;
    logic [BANK_W-1:0]       rr_q;
    logic [BANK_W-1:0]       win;
    logic [BANK_W-1:0]       nxt;
    logic                    found;
    logic                    open;
    logic                    grant;
    logic [PACKET_WIDTH-1:0] pkt_q;
    logic                    vld_q;

    always_comb begin
      cand = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        cand[b] = ret_pkt[b][VALID_POS] &&
                  (ret_pkt[b][PORT_ID_POS_LO +: PORT_ID_WIDTH] == PORT_ID_WIDTH'(p));
      end
    end

    unified_cache_xbar_rr_arb #(
      .N (NUM_BANK),
      .W (BANK_W)
    ) u_arb (
      .cand     (cand),
      .ptr      (rr_q),
      .found    (found),
      .win      (win),
      .next_ptr (nxt)
    );

    assign open  = !vld_q || return_packet_ack_in[p];
    assign grant = open && found && !reset_in;
    assign ret_gnt[p] = grant ? (NUM_BANK'(1) << win) : '0;

    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        pkt_q <= '0;
        vld_q <= 1'b0;
        rr_q  <= '0;
      end else if (grant) begin
        pkt_q <= ret_pkt[win];
        vld_q <= 1'b1;
        rr_q  <= nxt;
      end else if (vld_q && return_packet_ack_in[p]) begin
        pkt_q <= '0;
        vld_q <= 1'b0;
      end
    end

    assign return_packet_flatted_out[p*PACKET_WIDTH +: PACKET_WIDTH] = pkt_q;
  end

  // Each port targets a single bank (and each bank a single port), so OR-ing never double-counts.
  always_comb begin
    request_ack_out = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      request_ack_out = request_ack_out | req_gnt[b];
    end
  end

  always_comb begin
    bank_return_ack_out = '0;
    for (int p = 0; p < NUM_INPUT_PORT; p++) begin
      bank_return_ack_out = bank_return_ack_out | ret_gnt[p];
    end
  end

endmodule

// File: tb/tb_unified_cache_xbar.sv
// Bench for unified_cache_xbar: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of bank/port holding registers and round-robin pointers.
module tb_unified_cache_xbar;

  localparam int NP      = 2;
  localparam int NB      = 4;
  localparam int PW      = 40;
  localparam int VALID   = 39;
  localparam int PID_LO  = 36;
  localparam int N_RAND  = 2000;

`ifdef UNIFIED_CACHE_XBAR_CRITICAL_PRIORITY_EN
  localparam bit CRIT_EN = 1'b1;
`else
  localparam bit CRIT_EN = 1'b0;
`endif

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0]    req_pkt [NP];
  logic [PW-1:0]    ret_pkt [NB];
  logic [NP*PW-1:0] req_flat;
  logic [NB*PW-1:0] ret_flat;
  logic [NP-1:0]    crit;
  logic [NB-1:0]    bank_ack;
  logic [NP-1:0]    ret_ack;

  logic [NP-1:0]    request_ack_out;
  logic [NB*PW-1:0] bank_request_flatted_out;
  logic [NB-1:0]    bank_request_valid_out;
  logic [NB-1:0]    bank_return_ack_out;
  logic [NP*PW-1:0] return_packet_flatted_out;

  always_comb begin
    req_flat = '0;
    for (int p = 0; p < NP; p++) req_flat[p*PW +: PW] = req_pkt[p];
  end

  always_comb begin
    ret_flat = '0;
    for (int b = 0; b < NB; b++) ret_flat[b*PW +: PW] = ret_pkt[b];
  end

  unified_cache_xbar #(
    .NUM_INPUT_PORT  (NP),
    .NUM_BANK        (NB),
    .PACKET_WIDTH    (PW),
    .BANK_SEL_POS_LO (2),
    .PORT_ID_POS_LO  (PID_LO),
    .PORT_ID_WIDTH   (2),
    .VALID_POS       (VALID)
  ) dut (
    .clk_in                      (clk),
    .reset_in                    (rst),
    .request_flatted_in          (req_flat),
    .request_critical_flatted_in (crit),
    .request_ack_out             (request_ack_out),
    .bank_request_flatted_out    (bank_request_flatted_out),
    .bank_request_valid_out      (bank_request_valid_out),
    .bank_request_ack_in         (bank_ack),
    .bank_return_flatted_in      (ret_flat),
    .bank_return_ack_out         (bank_return_ack_out),
    .return_packet_flatted_out   (return_packet_flatted_out),
    .return_packet_ack_in        (ret_ack)
  );

  // scoreboard counters
  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: holding registers and round-robin pointers as plain arrays
  logic [PW-1:0] m_bpkt [NB];
  bit            m_bvld [NB];
  int            m_brr  [NB];
  logic [PW-1:0] m_ppkt [NP];
  bit            m_pvld [NP];
  int            m_prr  [NP];
  int            req_win [NB];
  int            ret_win [NP];
  logic [NP-1:0] exp_req_ack;
  logic [NB-1:0] exp_ret_ack;

  function automatic logic [PW-1:0] mk(input bit v, input int pid, input logic [31:0] addr);
    logic [PW-1:0] pk;
    pk = '0;
    pk[VALID] = v;
    pk[PID_LO +: 2] = pid[1:0];
    pk[31:0] = addr;
    return pk;
  endfunction

  function automatic int rr_pick(input logic [7:0] cand, input int rr, input int n);
    for (int k = 0; k < n; k++) begin
      if (cand[(rr + k) % n]) return (rr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_eval();
    logic [7:0] cand;
    logic [7:0] crit_c;
    exp_req_ack = '0;
    exp_ret_ack = '0;
    for (int b = 0; b < NB; b++) begin
      req_win[b] = -1;
      cand = '0;
      crit_c = '0;
      for (int p = 0; p < NP; p++) begin
        if (req_pkt[p][VALID] && int'(req_pkt[p][3:2]) == b) begin
          cand[p] = 1'b1;
          if (crit[p]) crit_c[p] = 1'b1;
        end
      end
      if (CRIT_EN && crit_c != 0) cand = crit_c;
      if (!rst && (!m_bvld[b] || bank_ack[b])) req_win[b] = rr_pick(cand, m_brr[b], NP);
      if (req_win[b] >= 0) exp_req_ack[req_win[b]] = 1'b1;
    end
    for (int p = 0; p < NP; p++) begin
      ret_win[p] = -1;
      cand = '0;
      for (int b = 0; b < NB; b++) begin
        if (ret_pkt[b][VALID] && int'(ret_pkt[b][PID_LO +: 2]) == p) cand[b] = 1'b1;
      end
      if (!rst && (!m_pvld[p] || ret_ack[p])) ret_win[p] = rr_pick(cand, m_prr[p], NB);
      if (ret_win[p] >= 0) exp_ret_ack[ret_win[p]] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        m_bpkt[b] = '0; m_bvld[b] = 0; m_brr[b] = 0;
      end else if (req_win[b] >= 0) begin
        m_bpkt[b] = req_pkt[req_win[b]]; m_bvld[b] = 1; m_brr[b] = (req_win[b] + 1) % NP;
      end else if (m_bvld[b] && bank_ack[b]) begin
        m_bpkt[b] = '0; m_bvld[b] = 0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        m_ppkt[p] = '0; m_pvld[p] = 0; m_prr[p] = 0;
      end else if (ret_win[p] >= 0) begin
        m_ppkt[p] = ret_pkt[ret_win[p]]; m_pvld[p] = 1; m_prr[p] = (ret_win[p] + 1) % NB;
      end else if (m_pvld[p] && ret_ack[p]) begin
        m_ppkt[p] = '0; m_pvld[p] = 0;
      end
    end
  endtask

  // driver: pre() checks the combinational acks for the inputs just driven, post() clocks and
  // checks the registered outputs.
  task automatic pre();
    #1;
    model_eval();
    check("req_ack", request_ack_out, exp_req_ack);
    check("ret_ack", bank_return_ack_out, exp_ret_ack);
  endtask

  task automatic post();
    logic [NB*PW-1:0] eb;
    logic [NB-1:0]    ev;
    logic [NP*PW-1:0] ep;
    @(posedge clk);
    model_commit();
    #1;
    for (int b = 0; b < NB; b++) begin
      eb[b*PW +: PW] = m_bpkt[b];
      ev[b] = m_bvld[b];
    end
    for (int p = 0; p < NP; p++) ep[p*PW +: PW] = m_ppkt[p];
    check("bank_pkt", bank_request_flatted_out, eb);
    check("bank_valid", bank_request_valid_out, ev);
    check("ret_pkt", return_packet_flatted_out, ep);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int b = 0; b < NB; b++) begin
      m_bpkt[b] = '0; m_bvld[b] = 0; m_brr[b] = 0; ret_pkt[b] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      m_ppkt[p] = '0; m_pvld[p] = 0; m_prr[p] = 0; req_pkt[p] = '0;
    end
    crit = '0;
    bank_ack = '0;
    ret_ack = '0;

    // reset with a packet offered: no ack, everything empty
    rst = 1'b1;
    req_pkt[0] = mk(1, 0, 32'h0000_0008);
    repeat (2) begin
      pre();
      check("reset_req_ack", request_ack_out, 0);
      post();
      check("reset_bank_valid", bank_request_valid_out, 0);
      check("reset_bank_pkt", bank_request_flatted_out, 0);
    end
    rst = 1'b0;

    // bank routing: address 0x8 lands in bank 2 in the first cycle after reset
    pre();
    check("route_ack", request_ack_out, 2'b01);
    post();
    check("route_valid", bank_request_valid_out, 4'b0100);
    check("route_pkt", bank_request_flatted_out[2*PW +: PW], mk(1, 0, 32'h0000_0008));
    req_pkt[0] = '0;

    // round-robin: both ports hammer bank 1 with the bank consuming every cycle
    req_pkt[0] = mk(1, 0, 32'h0000_0104);
    req_pkt[1] = mk(1, 1, 32'h0000_0204);
    bank_ack[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pre();
      check("rr_ack", request_ack_out, (i % 2 == 0) ? 2'b01 : 2'b10);
      post();
      check("rr_valid", bank_request_valid_out[1], 1);
      check("rr_pkt", bank_request_flatted_out[PW +: PW],
            (i % 2 == 0) ? mk(1, 0, 32'h0000_0104) : mk(1, 1, 32'h0000_0204));
    end
    req_pkt[0] = '0;
    req_pkt[1] = '0;
    pre();
    post();
    bank_ack[1] = 1'b0;

    // backpressure on bank 3
    req_pkt[0] = mk(1, 0, 32'h0000_00AC);
    pre();
    check("bp_first_ack", request_ack_out, 2'b01);
    post();
    req_pkt[0] = mk(1, 0, 32'h0000_00BC);
    repeat (5) begin
      pre();
      check("bp_hold_ack", request_ack_out, 0);
      post();
      check("bp_hold_pkt", bank_request_flatted_out[3*PW +: PW], mk(1, 0, 32'h0000_00AC));
    end
    bank_ack[3] = 1'b1;
    pre();
    check("bp_release_ack", request_ack_out, 2'b01);
    post();
    check("bp_new_pkt", bank_request_flatted_out[3*PW +: PW], mk(1, 0, 32'h0000_00BC));
    check("bp_no_bubble", bank_request_valid_out[3], 1);
    req_pkt[0] = '0;
    pre();
    post();
    bank_ack[3] = 1'b0;

    // return routing: banks 0 and 2 return to port 1, bank 1 carries port-id 3
    ret_pkt[0] = mk(1, 1, 32'h0000_0111);
    ret_pkt[2] = mk(1, 1, 32'h0000_0222);
    ret_pkt[1] = mk(1, 3, 32'h0000_0333);
    ret_ack = 2'b10;
    pre();
    check("ret_first_ack", bank_return_ack_out, 4'b0001);
    post();
    check("ret_first_pkt", return_packet_flatted_out[PW +: PW], mk(1, 1, 32'h0000_0111));
    check("ret_port0_idle", return_packet_flatted_out[0 +: PW], 0);
    ret_pkt[0] = '0;
    pre();
    check("ret_second_ack", bank_return_ack_out, 4'b0100);
    post();
    check("ret_second_pkt", return_packet_flatted_out[PW +: PW], mk(1, 1, 32'h0000_0222));
    ret_pkt[2] = '0;
    pre();
    check("ret_pid3_noack", bank_return_ack_out, 0);
    post();
    ret_pkt[1] = '0;
    ret_ack = '0;

    // critical priority on bank 0 with its pointer still at 0
    req_pkt[0] = mk(1, 0, 32'h0000_0000);
    req_pkt[1] = mk(1, 1, 32'h0000_0010);
    crit = 2'b10;
    pre();
    check("crit_ack", request_ack_out, CRIT_EN ? 2'b10 : 2'b01);
    post();
    req_pkt[0] = '0;
    req_pkt[1] = '0;
    crit = '0;

    // randomized traffic with a reset pulse in the middle
    for (int i = 0; i < N_RAND; i++) begin
      rst = (i == N_RAND / 2) || (i == N_RAND / 2 + 1);
      for (int p = 0; p < NP; p++) begin
        req_pkt[p] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
        crit[p] = 1'($urandom_range(0, 1));
      end
      for (int b = 0; b < NB; b++) begin
        ret_pkt[b] = mk($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom);
      end
      bank_ack = 4'($urandom);
      ret_ack = 2'($urandom);
      pre();
      post();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
